// File: rtl/axi_stream_hdr_pkg.sv
// Shared types and byte-count helpers for the AXI-Stream header insert/strip pair.
package axi_stream_hdr_pkg;

    localparam int unsigned DATA_WD      = 32;
    localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;
    localparam int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);
    localparam int unsigned RES_CNT_WD   = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_BODY, S_FLUSH} state_e;

    typedef logic [RES_CNT_WD-1:0]   cnt_t;
    typedef logic [DATA_BYTE_WD-1:0] keep_t;
    typedef logic [DATA_WD-1:0]      data_t;

    function automatic cnt_t keep2cnt(input keep_t keep);
        cnt_t cnt;
        cnt = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            cnt = cnt + cnt_t'(keep[i]);
        end
        return cnt;
    endfunction

    function automatic keep_t cnt2keep(input cnt_t cnt);
        keep_t keep;
        keep = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            keep[DATA_BYTE_WD-1-i] = (i < 32'(cnt));
        end
        return keep;
    endfunction

    function automatic data_t keep2mask(input keep_t keep);
        data_t mask;
        mask = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            mask[8*i +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_stream_out_slice.sv
// Single-entry valid/ready output register for an AXI-Stream beat.
module axi_stream_out_slice #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WD-1:0]      data_i,
    input  logic [DATA_BYTE_WD-1:0] keep_i,
    input  logic                    last_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [DATA_WD-1:0]      data_o,
    output logic [DATA_BYTE_WD-1:0] keep_o,
    output logic                    last_o
);

    logic                    valid_q;
    logic [DATA_WD-1:0]      data_q;
    logic [DATA_BYTE_WD-1:0] keep_q;
    logic                    last_q;

    assign in_ready_o = ~valid_q | ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            if (in_ready_o) begin
                valid_q <= in_valid_i;
            end
            if (in_valid_i && in_ready_o) begin
                data_q <= data_i;
                keep_q <= keep_i;
                last_q <= last_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips a 1..N byte header from the first beat of each packet and re-aligns the payload to byte 0.
module axi_stream_strip_header
    import axi_stream_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = axi_stream_hdr_pkg::DATA_WD,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    valid_strip,
    output logic                    ready_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    valid_hdr,
    input  logic                    ready_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr
);

    localparam logic [RES_CNT_WD:0] FULL_CNT = (RES_CNT_WD + 1)'(DATA_BYTE_WD);

    state_e                  state_q, state_d;
    cnt_t                    hlen_q, hlen_d;
    cnt_t                    res_cnt_q, res_cnt_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;
    logic                    hdr_valid_q, hdr_valid_d;

    logic                    in_acc;
    cnt_t                    k_cnt;
    logic [RES_CNT_WD:0]     tot_cnt;
    logic [DATA_WD-1:0]      din_m;

    logic                    s_valid, s_ready, s_last;
    logic [DATA_WD-1:0]      s_data;
    logic [DATA_BYTE_WD-1:0] s_keep;

    assign din_m   = data_in & keep2mask(keep_in);
    assign k_cnt   = keep2cnt(keep_in);
    assign tot_cnt = {1'b0, res_cnt_q} + {1'b0, k_cnt};
    assign in_acc  = valid_in & ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hlen_q      <= '0;
            res_cnt_q   <= '0;
            res_q       <= '0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
            hdr_valid_q <= 1'b0;
        end else begin
            hlen_q      <= hlen_d;
            res_cnt_q   <= res_cnt_d;
            res_q       <= res_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
            hdr_valid_q <= hdr_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hlen_d      = hlen_q;
        res_cnt_d   = res_cnt_q;
        res_d       = res_q;
        hdr_data_d  = hdr_data_q;
        hdr_keep_d  = hdr_keep_q;
        hdr_valid_d = hdr_valid_q & ~ready_hdr;
        unique case (state_q)
            S_IDLE: begin
                if (valid_strip) begin
                    hlen_d  = cnt_t'(byte_strip_cnt) + cnt_t'(1);
                    state_d = S_FIRST;
                end
            end
            S_FIRST: begin
                if (in_acc) begin
                    // an all-zero keep carries no bytes: a non-last one is dropped outright
                    if (keep_in == '0) begin
                        if (last_in) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        hdr_keep_d  = keep_in & cnt2keep(hlen_q);
                        hdr_data_d  = din_m & keep2mask(cnt2keep(hlen_q));
                        hdr_valid_d = 1'b1;
                        res_d       = din_m << (8 * hlen_q);
                        res_cnt_d   = (k_cnt > hlen_q) ? cnt_t'(k_cnt - hlen_q) : '0;
                        if (!last_in) begin
                            state_d = S_BODY;
                        end else if (k_cnt > hlen_q) begin
                            state_d = S_FLUSH;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_BODY: begin
                if (in_acc && (keep_in != '0 || last_in)) begin
                    res_d = din_m << (8 * (DATA_BYTE_WD - 32'(res_cnt_q)));
                    if (last_in) begin
                        if (tot_cnt > FULL_CNT) begin
                            res_cnt_d = cnt_t'(tot_cnt - FULL_CNT);
                            state_d   = S_FLUSH;
                        end else begin
                            res_cnt_d = '0;
                            res_d     = '0;
                            state_d   = S_IDLE;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (s_ready) begin
                    res_cnt_d = '0;
                    res_d     = '0;
                    state_d   = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready_strip = (state_q == S_IDLE);
        ready_in    = 1'b0;
        s_valid     = 1'b0;
        s_data      = res_q | (din_m >> (8 * res_cnt_q));
        s_keep      = '1;
        s_last      = 1'b0;
        unique case (state_q)
            S_FIRST: ready_in = ~hdr_valid_q | ready_hdr;
            S_BODY: begin
                ready_in = s_ready;
                s_valid  = valid_in & ((keep_in != '0) | last_in);
                if (last_in && tot_cnt <= FULL_CNT) begin
                    s_keep = cnt2keep(cnt_t'(tot_cnt));
                    s_last = 1'b1;
                end
            end
            S_FLUSH: begin
                s_valid = 1'b1;
                s_data  = res_q;
                s_keep  = cnt2keep(res_cnt_q);
                s_last  = 1'b1;
            end
            default: ;
        endcase
    end

    axi_stream_out_slice #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_out_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (s_valid),
        .in_ready_o (s_ready),
        .data_i     (s_data),
        .keep_i     (s_keep),
        .last_i     (s_last),
        .valid_o    (valid_out),
        .ready_i    (ready_out),
        .data_o     (data_out),
        .keep_o     (keep_out),
        .last_o     (last_out)
    );

    assign valid_hdr = hdr_valid_q;
    assign data_hdr  = hdr_data_q;
    assign keep_hdr  = hdr_keep_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: directed packets, mid-packet reset, then random packets under random backpressure.
module tb_axi_stream_strip_header;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, ready_in, last_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, last_out;
    logic        ready_out = 1'b1;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_strip, ready_strip;
    logic [1:0]  byte_strip_cnt;
    logic        valid_hdr;
    logic        ready_hdr = 1'b1;
    logic [31:0] data_hdr;
    logic [3:0]  keep_hdr;

    axi_stream_strip_header #(.DATA_WD(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .valid_strip    (valid_strip),
        .ready_strip    (ready_strip),
        .byte_strip_cnt (byte_strip_cnt),
        .valid_hdr      (valid_hdr),
        .ready_hdr      (ready_hdr),
        .data_hdr       (data_hdr),
        .keep_hdr       (keep_hdr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        int          cyc;
    } ob_t;

    int          checks = 0;
    int          failures = 0;
    int          pkt_id = 0;
    int          cyc = 0;
    bit          rand_ready = 1'b0;
    logic        ready_out_fix = 1'b1;
    logic        ready_hdr_fix = 1'b1;
    ob_t         out_q[$];
    ob_t         got[$];
    logic [31:0] hdr_d_q[$];
    logic [3:0]  hdr_k_q[$];
    int          acc_log[$];
    logic [7:0]  pkt[$];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        ready_out = rand_ready ? ($urandom_range(0, 1) == 1) : ready_out_fix;
        ready_hdr = rand_ready ? ($urandom_range(0, 1) == 1) : ready_hdr_fix;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_out && ready_out) out_q.push_back('{data_out, keep_out, last_out, cyc});
            if (valid_hdr && ready_hdr) begin
                hdr_d_q.push_back(data_hdr);
                hdr_k_q.push_back(keep_hdr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s pkt=%0d observed=0x%0h expected=0x%0h", tag, pkt_id, obs, exp);
        end
    endtask

    task automatic do_strip(input int h);
        bit done;
        done = 1'b0;
        valid_strip    = 1'b1;
        byte_strip_cnt = 2'(h - 1);
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            done = ready_strip;
            @(posedge clk); #1;
        end
        valid_strip = 1'b0;
        chk("strip_handshake", done, 1);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input bit l);
        bit done;
        done = 1'b0;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            done = ready_in;
            if (done) acc_log.push_back(cyc + 1);
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        chk("in_handshake", done, 1);
    endtask

    // Expected outputs come straight from the byte list: header = first H bytes,
    // payload = the rest, chopped into 4-byte beats starting at byte 0.
    task automatic run_pkt(input int h);
        int          n, nb, hl, npl, nexp, w;
        logic [31:0] d, ed, m;
        logic [3:0]  k, ek;
        logic [7:0]  pl[$];
        ob_t         o;
        n = pkt.size();
        acc_log = {};
        do_strip(h);
        nb = (n + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            d = '0; k = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * b + j < n) begin
                    d[31-8*j -: 8] = pkt[4*b+j];
                    k[3-j] = 1'b1;
                end
            end
            send(d, k, b == nb - 1);
        end
        hl = (h < n) ? h : n;
        ed = '0; ek = '0;
        for (int j = 0; j < hl; j++) begin
            ed[31-8*j -: 8] = pkt[j];
            ek[3-j] = 1'b1;
        end
        pl = {};
        for (int i = h; i < n; i++) pl.push_back(pkt[i]);
        npl  = pl.size();
        nexp = (npl + 3) / 4;
        w = 0;
        while ((hdr_d_q.size() == 0 || out_q.size() < nexp) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk("output_wait", w < 1000, 1);
        chk("hdr_count", hdr_d_q.size(), 1);
        if (hdr_d_q.size() > 0) begin
            chk("hdr_data", hdr_d_q[0], ed);
            chk("hdr_keep", hdr_k_q[0], ek);
        end
        chk("out_beats", out_q.size(), nexp);
        got = {};
        for (int b = 0; b < nexp && out_q.size() > 0; b++) begin
            o = out_q.pop_front();
            ed = '0; ek = '0; m = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * b + j < npl) begin
                    ed[31-8*j -: 8] = pl[4*b+j];
                    ek[3-j] = 1'b1;
                    m[31-8*j -: 8] = 8'hFF;
                end
            end
            chk("out_keep", o.k, ek);
            chk("out_last", o.l, b == nexp - 1);
            chk("out_data", o.d & m, ed);
            got.push_back(o);
        end
        out_q = {}; hdr_d_q = {}; hdr_k_q = {};
        chk("idle_after_pkt", ready_strip, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_strip = 1'b0; byte_strip_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_keep_out", keep_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_valid_hdr", valid_hdr, 0);
        chk("rst_keep_hdr", keep_hdr, 0);
        chk("rst_data_hdr", data_hdr, 0);
        chk("rst_ready_in", ready_in, 0);
        chk("rst_ready_strip", ready_strip, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // H=2, three full beats: payload needs a flush beat
        pkt_id++;
        pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_pkt(2);
        if (got.size() == 3 && acc_log.size() == 3) begin
            chk("h2_beat0", got[0].d, 32'hCCDD1122);
            chk("h2_beat1", got[1].d, 32'h33445566);
            chk("h2_flush_keep", got[2].k, 4'b1100);
            chk("h2_first_latency", got[0].cyc, acc_log[1]);
            chk("h2_steady_rate", got[1].cyc, got[0].cyc + 1);
            chk("h2_flush_one_cycle", got[2].cyc, got[1].cyc + 1);
        end

        // H=4: second beat passes unchanged
        pkt_id++;
        pkt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        run_pkt(4);
        if (got.size() == 1) chk("h4_keep", got[0].k, 4'b1110);

        // H=1, single beat
        pkt_id++;
        pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_pkt(1);
        if (got.size() == 1) chk("h1_data", got[0].d & 32'hFFFFFF00, 32'hBBCCDD00);

        // H=3, two-byte packet: header only, no payload
        pkt_id++;
        pkt = {8'h5A, 8'hA5};
        run_pkt(3);

        // reset in the middle of a packet while a payload beat is held
        pkt_id++;
        ready_out_fix = 1'b0; ready_hdr_fix = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        do_strip(1);
        send(32'h01020304, 4'hF, 1'b0);
        send(32'h05060708, 4'hF, 1'b0);
        chk("mid_valid_out", valid_out, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_out", valid_out, 0);
        chk("mid_rst_last_out", last_out, 0);
        chk("mid_rst_keep_out", keep_out, 0);
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_valid_hdr", valid_hdr, 0);
        chk("mid_rst_data_hdr", data_hdr, 0);
        chk("mid_rst_ready_in", ready_in, 0);
        chk("mid_rst_ready_strip", ready_strip, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_out_fix = 1'b1; ready_hdr_fix = 1'b1;
        @(posedge clk); #1;
        out_q = {}; hdr_d_q = {}; hdr_k_q = {};
        pkt_id++;
        pkt = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        run_pkt(3);

        // random packets under random backpressure on both output channels
        rand_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            int n;
            int h;
            n = $urandom_range(1, 16);
            h = $urandom_range(1, 4);
            pkt = {};
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            pkt_id++;
            run_pkt(h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
